sram_port_arbiter: RTL and testbench

//  Shares one sram_controller between NUM_REQ requesters with round-robin arbitration.
//  Per requester: valid/ready request channel (addr, we, wdata) and a one-cycle response strobe.

---
 rtl/sram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin front end that shares one sram_controller
// between NUM_REQ requesters. One access is in flight at a time; the
// controller strobes are decoded from the state register so they are glitch
// free and line up exactly with the ISSUE/HOLD/DONE phases.
//
// Handshake: a requester raises req_valid with stable addr/we/wdata and keeps
// them stable until it sees req_ready in the same cycle; the transfer happens
// on the rising edge where req_valid & req_ready are both 1. req_ready is only
// ever offered in IDLE (and never under reset), to at most one requester.
// rsp_valid is a one-cycle strobe to the owner with no back-pressure.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REQ       = 2,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           mem_cs,
  output logic                           mem_we,
  output logic                           mem_oe,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic                           mem_wdata_oe,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic [1:0]                     dbg_state
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(ACCESS_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_RESET = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CW-1:0]       cnt;
  logic [IDW-1:0]      last_grant;
  logic [IDW-1:0]      owner;
  logic                we_l;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                win_found;
  logic [IDW-1:0]      win_id;
  int                  arb_idx;
  logic                handshake;
  logic                in_access;

  // Round-robin search: first pending requester after the last one granted.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    arb_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_found && req_valid[arb_idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(arb_idx);
      end
    end
  end

  assign handshake = (state == S_IDLE) && !reset && win_found;

  // Offer ready to the winner only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[win_id] = 1'b1;
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|req_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = (ACCESS_CYCLES == 1) ? S_DONE : S_HOLD;
      S_HOLD:  if (cnt == CNT_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and access-length counter; reset aborts any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_ISSUE: cnt <= CW'(1);
        S_HOLD:  if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Request capture on handshake, grant history, and read-data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_RESET;
      owner      <= '0;
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      rdata_q    <= '0;
    end else begin
      if (handshake) begin
        last_grant <= win_id;
        owner      <= win_id;
        we_l       <= req_we[win_id];
        addr_l     <= req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_l    <= req_wdata[win_id*DATA_WIDTH +: DATA_WIDTH];
      end
      // Bus data is valid in the last access cycle, just before DONE.
      if (state != S_DONE && state_nx == S_DONE && !we_l) rdata_q <= mem_rdata;
    end
  end

  // Completion strobe goes only to the owner of the finished access.
  always_comb begin
    rsp_valid = '0;
    if (state == S_DONE) rsp_valid[owner] = 1'b1;
  end

  assign in_access    = (state == S_ISSUE) || (state == S_HOLD);
  assign mem_cs       = (state == S_ISSUE);
  assign mem_we       = in_access & we_l;
  assign mem_oe       = in_access & ~we_l;
  assign mem_wdata_oe = in_access & we_l;
  assign mem_addr     = addr_l;
  assign mem_wdata    = wdata_l;
  assign rsp_rdata    = rdata_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances cover the default
// configuration (A), four requesters (B) and single-cycle accesses (C).
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  // Instance A: NUM_REQ=2, ACCESS_CYCLES=3
  logic [1:0]  req_valid_a, req_we_a, req_ready_a, rsp_valid_a, dbg_a;
  logic [31:0] req_addr_a;
  logic [15:0] req_wdata_a;
  logic [7:0]  rsp_rdata_a, mem_wdata_a, mem_rdata_a, rdata_drv;
  logic [15:0] mem_addr_a;
  logic        mem_cs_a, mem_we_a, mem_oe_a, mem_wdata_oe_a;

  // Instance B: NUM_REQ=4, ACCESS_CYCLES=3
  logic [3:0]  req_valid_b, req_we_b, req_ready_b, rsp_valid_b;
  logic [1:0]  dbg_b;
  logic [63:0] req_addr_b;
  logic [31:0] req_wdata_b;
  logic [7:0]  rsp_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [15:0] mem_addr_b;
  logic        mem_cs_b, mem_we_b, mem_oe_b, mem_wdata_oe_b;

  // Instance C: NUM_REQ=2, ACCESS_CYCLES=1
  logic [1:0]  req_valid_c, req_we_c, req_ready_c, rsp_valid_c, dbg_c;
  logic [31:0] req_addr_c;
  logic [15:0] req_wdata_c;
  logic [7:0]  rsp_rdata_c, mem_wdata_c, mem_rdata_c;
  logic [15:0] mem_addr_c;
  logic        mem_cs_c, mem_we_c, mem_oe_c, mem_wdata_oe_c;

  int n_vec  = 0;
  int n_miss = 0;

  // Scoreboard entry: {we, owner[1:0], data[7:0]}
  logic [10:0] exp_q[$];
  logic [10:0] sb_e;
  logic [7:0]  last_rd;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Read data only appears on the bus while the output enable is on.
  assign mem_rdata_a = mem_oe_a ? rdata_drv : 8'h00;
  assign mem_rdata_b = 8'h00;
  assign mem_rdata_c = 8'h00;

  sram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_REQ(2), .ACCESS_CYCLES(3)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_ready(req_ready_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .mem_cs(mem_cs_a),
    .mem_we(mem_we_a), .mem_oe(mem_oe_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_wdata_oe(mem_wdata_oe_a),
    .mem_rdata(mem_rdata_a), .dbg_state(dbg_a)
  );

  sram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_REQ(4), .ACCESS_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .mem_cs(mem_cs_b),
    .mem_we(mem_we_b), .mem_oe(mem_oe_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_wdata_oe(mem_wdata_oe_b),
    .mem_rdata(mem_rdata_b), .dbg_state(dbg_b)
  );

  sram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_REQ(2), .ACCESS_CYCLES(1)) dut_c (
    .clk(clk), .reset(reset), .req_valid(req_valid_c), .req_we(req_we_c),
    .req_addr(req_addr_c), .req_wdata(req_wdata_c), .req_ready(req_ready_c),
    .rsp_valid(rsp_valid_c), .rsp_rdata(rsp_rdata_c), .mem_cs(mem_cs_c),
    .mem_we(mem_we_c), .mem_oe(mem_oe_c), .mem_addr(mem_addr_c),
    .mem_wdata(mem_wdata_c), .mem_wdata_oe(mem_wdata_oe_c),
    .mem_rdata(mem_rdata_c), .dbg_state(dbg_c)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every completion strobe on A must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) last_rd = 8'h00;
    if (rsp_valid_a != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {30'd0, rsp_valid_a}, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("rsp_owner", {30'd0, rsp_valid_a}, 32'd1 << sb_e[9:8]);
        if (!sb_e[10]) begin
          check("rsp_rdata", {24'd0, rsp_rdata_a}, {24'd0, sb_e[7:0]});
          last_rd = sb_e[7:0];
        end else begin
          check("rsp_rdata_hold", {24'd0, rsp_rdata_a}, {24'd0, last_rd});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = |(req_valid_a & req_ready_a);
        1:       ok = |(req_valid_b & req_ready_b);
        default: ok = |(req_valid_c & req_ready_c);
      endcase
    end
  endtask

  // One complete access on instance A with pin-level timing checks.
  task automatic do_access(input int id, input logic we, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] rd);
    bit ok;
    @(posedge clk); #1;
    req_we_a[id]            = we;
    req_addr_a[id*16 +: 16] = addr;
    req_wdata_a[id*8 +: 8]  = wd;
    req_valid_a[id]         = 1'b1;
    rdata_drv               = rd;
    wait_ready(0, 20, ok);
    check("hs_wait", {31'd0, ok}, 32'd1);
    if (!ok) begin
      req_valid_a[id] = 1'b0;
      return;
    end
    check("ready", {30'd0, req_ready_a}, 32'd1 << id);
    exp_q.push_back({we, 2'(id), (we ? wd : rd)});
    @(posedge clk); #1;
    req_valid_a[id] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("mem_cs", {31'd0, mem_cs_a}, (k == 1) ? 32'd1 : 32'd0);
      check("mem_we", {31'd0, mem_we_a}, {31'd0, we});
      check("mem_oe", {31'd0, mem_oe_a}, {31'd0, ~we});
      check("mem_wdata_oe", {31'd0, mem_wdata_oe_a}, {31'd0, we});
      check("mem_addr", {16'd0, mem_addr_a}, {16'd0, addr});
      if (we) check("mem_wdata", {24'd0, mem_wdata_a}, {24'd0, wd});
      check("ready_busy", {30'd0, req_ready_a}, 32'd0);
    end
    @(negedge clk);
    check("done_strobes", {29'd0, mem_we_a, mem_oe_a, mem_wdata_oe_a}, 32'd0);
    check("done_rsp_valid", {30'd0, rsp_valid_a}, 32'd1 << id);
    check("done_addr_keep", {16'd0, mem_addr_a}, {16'd0, addr});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    reset = 1'b1;
    req_valid_a = '0; req_we_a = '0; req_addr_a = '0; req_wdata_a = '0; rdata_drv = '0;
    req_valid_b = '0; req_we_b = '0; req_addr_b = '0; req_wdata_b = '0;
    req_valid_c = '0; req_we_c = '0; req_addr_c = '0; req_wdata_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_a", {4'd0, mem_cs_a, mem_we_a, mem_oe_a, mem_wdata_oe_a, mem_addr_a, mem_wdata_a}, 32'd0);
    check("reset_req_a", {18'd0, req_ready_a, rsp_valid_a, rsp_rdata_a, dbg_a}, 32'd0);
    check("reset_mem_b", {4'd0, mem_cs_b, mem_we_b, mem_oe_b, mem_wdata_oe_b, mem_addr_b, mem_wdata_b}, 32'd0);
    check("reset_req_b", {14'd0, req_ready_b, rsp_valid_b, rsp_rdata_b, dbg_b}, 32'd0);
    check("reset_mem_c", {4'd0, mem_cs_c, mem_we_c, mem_oe_c, mem_wdata_oe_c, mem_addr_c, mem_wdata_c}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: write by requester 0 straight out of reset
    do_access(0, 1'b1, 16'h0010, 8'hA5, 8'h00);
    // 2: read by requester 1, bus returns 0x5A
    do_access(1, 1'b0, 16'h1234, 8'h00, 8'h5A);
    // a few random single accesses, alternating owners
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ra;
      logic [7:0]  rw;
      ra = 16'($urandom_range(0, 16'hFFFF));
      rw = 8'($urandom_range(0, 255));
      do_access(i % 2, 1'($urandom_range(0, 1)), ra, rw, ~rw);
    end

    // 3: both requesters held -> strict rotation, 5 cycles apart
    @(posedge clk); #1;
    req_we_a = 2'b11;
    req_addr_a = {16'h0200, 16'h0100};
    req_wdata_a = {8'h22, 8'h11};
    exp_q.push_back({1'b1, 2'd0, 8'h11});
    exp_q.push_back({1'b1, 2'd1, 8'h22});
    exp_q.push_back({1'b1, 2'd0, 8'h11});
    exp_q.push_back({1'b1, 2'd1, 8'h22});
    req_valid_a = 2'b11;
    wait_ready(0, 20, ok);
    check("rr_wait", {31'd0, ok}, 32'd1);
    check("rr_first", {30'd0, req_ready_a}, 32'd1);
    for (int g = 1; g <= 3; g++) begin
      repeat (5) @(negedge clk);
      check("rr_grant", {30'd0, req_ready_a}, (g % 2 == 1) ? 32'd2 : 32'd1);
    end
    @(posedge clk); #1;
    req_valid_a = 2'b00;
    repeat (6) @(negedge clk);

    // 4: reset during HOLD aborts; next contested grant goes to requester 0
    @(posedge clk); #1;
    req_we_a = 2'b00;
    req_addr_a = {16'h0044, 16'h0033};
    rdata_drv = 8'h77;
    req_valid_a = 2'b01;
    wait_ready(0, 20, ok);
    check("abort_hs_wait", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req_valid_a = 2'b00;
    @(negedge clk);
    check("abort_issue_cs", {31'd0, mem_cs_a}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid_a = 2'b10;
    @(negedge clk);
    check("abort_hold_oe", {31'd0, mem_oe_a}, 32'd1);
    @(negedge clk);
    check("abort_mem", {4'd0, mem_cs_a, mem_we_a, mem_oe_a, mem_wdata_oe_a, mem_addr_a, mem_wdata_a}, 32'd0);
    check("abort_rsp", {30'd0, rsp_valid_a}, 32'd0);
    check("abort_ready", {30'd0, req_ready_a}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_we_a = 2'b11;
    req_wdata_a = {8'h66, 8'h55};
    exp_q.push_back({1'b1, 2'd0, 8'h55});
    req_valid_a = 2'b11;
    @(negedge clk);
    check("post_reset_grant", {30'd0, req_ready_a}, 32'd1);
    @(posedge clk); #1;
    req_valid_a = 2'b00;
    repeat (6) @(negedge clk);

    // 5: four requesters, 2 and 3 alternate; 0 raised in DONE waits for IDLE
    @(posedge clk); #1;
    req_addr_b = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req_valid_b = 4'b1100;
    wait_ready(1, 20, ok);
    check("b_wait", {31'd0, ok}, 32'd1);
    check("b_first", {28'd0, req_ready_b}, 32'h4);
    for (int g = 1; g <= 3; g++) begin
      repeat (5) @(negedge clk);
      check("b_grant", {28'd0, req_ready_b}, (g % 2 == 1) ? 32'h8 : 32'h4);
    end
    repeat (4) @(posedge clk);
    #1;
    req_valid_b[0] = 1'b1;
    @(negedge clk);
    check("b_done_rsp", {28'd0, rsp_valid_b}, 32'h8);
    check("b_done_no_ready", {28'd0, req_ready_b}, 32'h0);
    @(negedge clk);
    check("b_idle_grant0", {28'd0, req_ready_b}, 32'h1);
    @(posedge clk); #1;
    req_valid_b = 4'b0000;

    // 6: single-cycle accesses, ISSUE->DONE, handshakes 3 cycles apart
    @(posedge clk); #1;
    req_we_c = 2'b01;
    req_addr_c = {16'h00C1, 16'h00C0};
    req_wdata_c = {8'h00, 8'h3C};
    req_valid_c = 2'b11;
    wait_ready(2, 20, ok);
    check("c_wait", {31'd0, ok}, 32'd1);
    check("c_first", {30'd0, req_ready_c}, 32'd1);
    @(negedge clk);
    check("c_issue", {29'd0, mem_cs_c, mem_we_c, mem_wdata_oe_c}, 32'h7);
    @(negedge clk);
    check("c_rsp0", {30'd0, rsp_valid_c}, 32'd1);
    check("c_done_cs", {31'd0, mem_cs_c}, 32'd0);
    @(negedge clk);
    check("c_grant1", {30'd0, req_ready_c}, 32'd2);
    @(negedge clk);
    check("c_issue_rd", {30'd0, mem_oe_c, mem_we_c}, 32'h2);
    @(negedge clk);
    check("c_rsp1", {30'd0, rsp_valid_c}, 32'd2);
    @(negedge clk);
    check("c_grant0", {30'd0, req_ready_c}, 32'd1);
    @(posedge clk); #1;
    req_valid_c = 2'b00;

    repeat (6) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
